// File: rtl/apb_node_pkg.sv
// Shared types and constants for the registered APB node (apb_node_reg).
package apb_node_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    DERR
  } state_t;

  localparam int MAX_DATA_WIDTH = 64;

  // Read data returned with a decode-error response.
  localparam logic [MAX_DATA_WIDTH-1:0] DERR_RDATA = '0;

  function automatic int strbWidth(input int dataWidth);
    return dataWidth / 8;
  endfunction

endpackage

// File: rtl/apb_node_decoder.sv
// Priority range decoder for apb_node_reg: one-hot select of the lowest-index
// port whose inclusive [start, end] range contains the address.
module apb_node_decoder #(
  parameter int NB_MASTER      = 8,
  parameter int APB_ADDR_WIDTH = 32
) (
  input  logic [APB_ADDR_WIDTH-1:0]                i_addr,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] i_startAddr,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] i_endAddr,
  output logic [NB_MASTER-1:0]                     o_sel,
  output logic                                     o_hit
);

  // A range with start above end can never satisfy both compares.
  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    for (int i = 0; i < NB_MASTER; i++) begin
      if (!o_hit && (i_startAddr[i] <= i_addr) && (i_addr <= i_endAddr[i])) begin
        o_sel[i] = 1'b1;
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_node_reg.sv
// Registered single-outstanding APB demultiplexer with decode-error response.
// Optional access timeout enabled by defining APB_NODE_TIMEOUT_EN.
module apb_node_reg
  import apb_node_pkg::*;
#(
  parameter int NB_MASTER      = 8,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     psel_i,
  input  logic                                     penable_i,
  input  logic                                     pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]                paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                pwdata_i,
  input  logic [strbWidth(APB_DATA_WIDTH)-1:0]     pstrb_i,
  output logic [APB_DATA_WIDTH-1:0]                prdata_o,
  output logic                                     pready_o,
  output logic                                     pslverr_o,
  output logic [NB_MASTER-1:0]                     psel_o,
  output logic                                     penable_o,
  output logic                                     pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
  output logic [strbWidth(APB_DATA_WIDTH)-1:0]     pstrb_o,
  input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NB_MASTER-1:0]                     pready_i,
  input  logic [NB_MASTER-1:0]                     pslverr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] END_ADDR_i
);

  localparam int STRB_W = strbWidth(APB_DATA_WIDTH);

  state_t                    r_state;
  logic [NB_MASTER-1:0]      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic [STRB_W-1:0]         r_pstrb;
  logic [APB_DATA_WIDTH-1:0] r_prdata;
  logic                      r_pready;
  logic                      r_pslverr;

  logic [NB_MASTER-1:0]      w_sel;
  logic                      w_hit;
  logic                      w_ready;
  logic                      w_slvErr;
  logic [APB_DATA_WIDTH-1:0] w_rdata;

`ifdef APB_NODE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = (TIMEOUT_CYCLES > 0);
`endif

  apb_node_decoder #(
    .NB_MASTER      (NB_MASTER),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
  ) u_decoder (
    .i_addr      (paddr_i),
    .i_startAddr (START_ADDR_i),
    .i_endAddr   (END_ADDR_i),
    .o_sel       (w_sel),
    .o_hit       (w_hit)
  );

  // r_psel still holds the captured one-hot select while in ACCESS.
  assign w_ready  = |(pready_i & r_psel);
  assign w_slvErr = |(pslverr_i & r_psel);

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NB_MASTER; i++) begin
      if (r_psel[i]) begin
        w_rdata = w_rdata | prdata_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // Only the setup phase starts a transfer, so a held access phase is never re-captured.
          if (psel_i && !penable_i) begin
            if (w_hit) begin
              r_state  <= SETUP;
              r_psel   <= w_sel;
              r_pwrite <= pwrite_i;
              r_paddr  <= paddr_i;
              r_pwdata <= pwdata_i;
              r_pstrb  <= pstrb_i;
            end else begin
              r_state   <= DERR;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_prdata  <= DERR_RDATA[APB_DATA_WIDTH-1:0];
            end
          end
        end

        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
`ifdef APB_NODE_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end

        ACCESS: begin
          if (w_ready) begin
            r_state   <= RESP;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pready  <= 1'b1;
            r_pslverr <= w_slvErr;
            r_prdata  <= r_pwrite ? '0 : w_rdata;
`ifdef APB_NODE_TIMEOUT_EN
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= RESP;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
            r_prdata  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end

        RESP, DERR: begin
          r_state   <= IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign prdata_o  = r_prdata;
  assign pready_o  = r_pready;
  assign pslverr_o = r_pslverr;
  assign psel_o    = r_psel;
  assign penable_o = r_penable;
  assign pwrite_o  = r_pwrite;
  assign paddr_o   = r_paddr;
  assign pwdata_o  = r_pwdata;
  assign pstrb_o   = r_pstrb;

endmodule

// File: tb/tb_apb_node_reg.sv
// Self-checking bench for apb_node_reg; timeout cases run when APB_NODE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_apb_node_reg;

  localparam int NB = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   psel_i, penable_i, pwrite_i;
  logic [AW-1:0]          paddr_i;
  logic [DW-1:0]          pwdata_i;
  logic [SW-1:0]          pstrb_i;
  logic [DW-1:0]          prdata_o;
  logic                   pready_o, pslverr_o;
  logic [NB-1:0]          psel_o;
  logic                   penable_o, pwrite_o;
  logic [AW-1:0]          paddr_o;
  logic [DW-1:0]          pwdata_o;
  logic [SW-1:0]          pstrb_o;
  logic [NB-1:0][DW-1:0]  prdata_i;
  logic [NB-1:0]          pready_i, pslverr_i;
  logic [NB-1:0][AW-1:0]  startAddr, endAddr;

  apb_node_reg #(
    .NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .START_ADDR_i(startAddr), .END_ADDR_i(endAddr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle, filled in by the stimulus task.
  logic          expValid = 1'b0;
  logic          expBusValid;
  logic [NB-1:0] expPsel;
  logic          expPenable, expPwrite, expPready, expPslverr;
  logic [AW-1:0] expPaddr;
  logic [DW-1:0] expPwdata, expPrdata;
  logic [SW-1:0] expPstrb;

  logic [AW-1:0] startTab [NB];
  logic [AW-1:0] endTab [NB];

  int            obsFirstReady;
  int            obsReadyCount;
  logic [NB-1:0] obsPselCycle1;
  logic [NB-1:0] obsPselUnion;
  logic [DW-1:0] obsPrdata;
  logic          obsErr;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expValid) begin
      checkOutput("psel_o", 64'(psel_o), 64'(expPsel));
      checkOutput("penable_o", 64'(penable_o), 64'(expPenable));
      checkOutput("pready_o", 64'(pready_o), 64'(expPready));
      checkOutput("pslverr_o", 64'(pslverr_o), 64'(expPslverr));
      checkOutput("prdata_o", 64'(prdata_o), 64'(expPrdata));
      if (expBusValid) begin
        checkOutput("pwrite_o", 64'(pwrite_o), 64'(expPwrite));
        checkOutput("paddr_o", 64'(paddr_o), 64'(expPaddr));
        checkOutput("pwdata_o", 64'(pwdata_o), 64'(expPwdata));
        checkOutput("pstrb_o", 64'(pstrb_o), 64'(expPstrb));
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_psel"}, 64'(psel_o), 64'd0);
    checkOutput({tag, "_penable"}, 64'(penable_o), 64'd0);
    checkOutput({tag, "_pready"}, 64'(pready_o), 64'd0);
    checkOutput({tag, "_pslverr"}, 64'(pslverr_o), 64'd0);
    checkOutput({tag, "_prdata"}, 64'(prdata_o), 64'd0);
    checkOutput({tag, "_paddr"}, 64'(paddr_o), 64'd0);
    checkOutput({tag, "_pwdata"}, 64'(pwdata_o), 64'd0);
    checkOutput({tag, "_pstrb"}, 64'(pstrb_o), 64'd0);
    checkOutput({tag, "_pwrite"}, 64'(pwrite_o), 64'd0);
  endtask

  // One upstream transfer; slave on the decoded port is ready after 'waits' ACCESS wait cycles.
  // Called just after a rising edge; that cycle is cycle 0 (upstream setup phase).
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [SW-1:0] strb, input int waits, input logic [DW-1:0] rdata,
                               input logic err, input logic dropSel);
    int   port;
    logic hit;
    int   effWaits;
    logic timedOut;
    int   respCycle;
    hit = 1'b0;
    port = 0;
    for (int i = 0; i < NB; i++) begin
      if (!hit && startTab[i] <= addr && addr <= endTab[i]) begin
        hit = 1'b1;
        port = i;
      end
    end
    effWaits = waits;
    timedOut = 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
    if (hit && waits >= TO) begin
      effWaits = TO - 1;
      timedOut = 1'b1;
    end
`endif
    respCycle = hit ? 3 + effWaits : 1;
    obsFirstReady = -1;
    obsReadyCount = 0;
    obsPselCycle1 = '0;
    obsPselUnion = '0;
    obsPrdata = '0;
    obsErr = 1'b0;
    for (int c = 0; c <= respCycle + 1; c++) begin
      psel_i    = (c == 0) || (c <= respCycle && !dropSel);
      penable_i = (c >= 1) && (c <= respCycle) && !dropSel;
      pwrite_i  = wr;
      paddr_i   = addr;
      pwdata_i  = wdata;
      pstrb_i   = strb;
      for (int i = 0; i < NB; i++) begin
        prdata_i[i]  = 32'hBAD0_0000 | 32'(i);
        pready_i[i]  = 1'b1;
        pslverr_i[i] = 1'b1;
      end
      if (hit) begin
        prdata_i[port]  = rdata;
        pready_i[port]  = (c == 2 + waits);
        pslverr_i[port] = err;
      end
      expValid = 1'b1;
      expBusValid = 1'b1;
      expPsel = '0;
      expPenable = 1'b0;
      expPwrite = 1'b0;
      expPaddr = '0;
      expPwdata = '0;
      expPstrb = '0;
      expPready = 1'b0;
      expPslverr = 1'b0;
      expPrdata = '0;
      if (hit && c >= 1 && c <= 2 + effWaits) begin
        expPsel[port] = 1'b1;
        expPenable = (c >= 2);
        expPwrite = wr;
        expPaddr = addr;
        expPwdata = wdata;
        expPstrb = strb;
      end else if (c == respCycle) begin
        expBusValid = 1'b0;
        expPready = 1'b1;
        expPslverr = hit ? (timedOut | err) : 1'b1;
        expPrdata = (hit && !wr && !timedOut) ? rdata : '0;
      end
      @(negedge clk);
      if (c == 1) obsPselCycle1 = psel_o;
      obsPselUnion = obsPselUnion | psel_o;
      if (pready_o) begin
        obsReadyCount++;
        if (obsFirstReady < 0) begin
          obsFirstReady = c;
          obsPrdata = prdata_o;
          obsErr = pslverr_o;
        end
      end
      @(posedge clk);
      #1;
    end
    expValid = 1'b0;
    psel_i = 1'b0;
    penable_i = 1'b0;
  endtask

  task automatic resetDuringAccess();
    expValid = 1'b0;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = 32'h5040; pwdata_i = '0; pstrb_i = '0;
    pready_i = '0; pslverr_i = '0;
    @(posedge clk); #1;
    penable_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre_reset_penable", 64'(penable_o), 64'd1);
    checkOutput("pre_reset_psel", 64'(psel_o), 64'h20);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_reset");
    psel_i = 1'b0; penable_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkAllZero("after_reset");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    startTab[0] = 32'h0000_0000; endTab[0] = 32'h0000_0FFF;
    startTab[1] = 32'h0000_1000; endTab[1] = 32'h0000_1FFF;
    startTab[2] = 32'h0000_2000; endTab[2] = 32'h0000_2FFF;
    startTab[3] = 32'h0000_1800; endTab[3] = 32'h0000_3FFF;
    startTab[4] = 32'h0000_5000; endTab[4] = 32'h0000_4000;
    startTab[5] = 32'h0000_5000; endTab[5] = 32'h0000_5FFF;
    startTab[6] = 32'h0000_6000; endTab[6] = 32'h0000_6000;
    startTab[7] = 32'hFFFF_F000; endTab[7] = 32'hFFFF_FFFF;
    for (int i = 0; i < NB; i++) begin
      startAddr[i] = startTab[i];
      endAddr[i] = endTab[i];
    end
    rst_n = 1'b0;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
    prdata_i = '0; pready_i = '0; pslverr_i = '0;
    #12;
    checkAllZero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] write port 2, zero wait");
    applyStimulus(1'b1, 32'h2004, 32'h1A2B3C4D, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    checkOutput("w2_psel_cycle1", 64'(obsPselCycle1), 64'h04);
    checkOutput("w2_ready_cycle", 64'(obsFirstReady), 64'd3);
    checkOutput("w2_err", 64'(obsErr), 64'd0);

    $display("[TB] read port 5, three waits");
    applyStimulus(1'b0, 32'h5010, 32'h0, 4'h0, 3, 32'hCAFEF00D, 1'b0, 1'b0);
    checkOutput("r5_ready_cycle", 64'(obsFirstReady), 64'd6);
    checkOutput("r5_prdata", 64'(obsPrdata), 64'hCAFEF00D);
    checkOutput("r5_ready_count", 64'(obsReadyCount), 64'd1);

    $display("[TB] overlap 1/3");
    applyStimulus(1'b0, 32'h1900, 32'h0, 4'h0, 1, 32'h1111_2222, 1'b0, 1'b0);
    checkOutput("ovl_psel_cycle1", 64'(obsPselCycle1), 64'h02);

    $display("[TB] unmapped address");
    applyStimulus(1'b0, 32'h7000, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0);
    checkOutput("miss_ready_cycle", 64'(obsFirstReady), 64'd1);
    checkOutput("miss_err", 64'(obsErr), 64'd1);
    checkOutput("miss_psel_union", 64'(obsPselUnion), 64'd0);

    applyStimulus(1'b0, 32'h4800, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h5FFF, 32'h0, 4'h0, 1, 32'h0BAD_BEEF, 1'b1, 1'b0);
    checkOutput("r5end_err", 64'(obsErr), 64'd1);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h8765_4321, 4'h5, 2, 32'hDEAD_0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h6000, 32'h0, 4'h0, 2, 32'h6666_6666, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, 32'h0000_ABCD, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h6001, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h2800, 32'h0, 4'h0, 0, 32'h2222_8888, 1'b0, 1'b0);

`ifdef APB_NODE_TIMEOUT_EN
    $display("[TB] timeout, slave never ready");
    applyStimulus(1'b0, 32'h5020, 32'h0, 4'h0, 1000, 32'h1234_5678, 1'b0, 1'b0);
    checkOutput("to_ready_cycle", 64'(obsFirstReady), 64'd18);
    checkOutput("to_err", 64'(obsErr), 64'd1);
    checkOutput("to_prdata", 64'(obsPrdata), 64'd0);
    applyStimulus(1'b0, 32'h5020, 32'h0, 4'h0, 15, 32'h1234_5678, 1'b0, 1'b0);
    checkOutput("to_edge_ready_cycle", 64'(obsFirstReady), 64'd18);
    checkOutput("to_edge_err", 64'(obsErr), 64'd0);
    checkOutput("to_edge_prdata", 64'(obsPrdata), 64'h1234_5678);
`else
    applyStimulus(1'b0, 32'h5020, 32'h0, 4'h0, 20, 32'h1234_5678, 1'b0, 1'b0);
    checkOutput("long_wait_ready_cycle", 64'(obsFirstReady), 64'd23);
`endif

    $display("[TB] reset during access");
    resetDuringAccess();
    applyStimulus(1'b0, 32'h2010, 32'h0, 4'h0, 0, 32'h5A5A_A5A5, 1'b0, 1'b0);
    checkOutput("post_reset_ready_cycle", 64'(obsFirstReady), 64'd3);
    checkOutput("post_reset_prdata", 64'(obsPrdata), 64'h5A5A_A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_node_reg.md
Name: apb_node_reg

Overview:
- Registered, single-outstanding APB3/APB4 demultiplexer. Successor to the combinational APB node.
- Sits between one upstream APB master (bridge) and NB_MASTER downstream peripheral ports.
- Adds the following over the combinational node:
  - registered request path, which breaks the decode timing path;
  - priority decode with an explicit decode-error response;
  - byte strobes;
  - parametrised widths;
  - an optional access timeout.

Parameters:
- NB_MASTER, 8, number of downstream ports (1..32).
- APB_ADDR_WIDTH, 32, address width of paddr and the range registers.
- APB_DATA_WIDTH, 32, data width (32 or 64). Strobe width is APB_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, maximum ACCESS-state cycles before abort (used only with the timeout feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- psel_i  in  1  upstream select.
- penable_i  in  1  upstream enable.
- pwrite_i  in  1  upstream write.
- paddr_i  in  APB_ADDR_WIDTH  upstream address.
- pwdata_i  in  APB_DATA_WIDTH  upstream write data.
- pstrb_i  in  APB_DATA_WIDTH/8  upstream byte strobes.
- prdata_o  out  APB_DATA_WIDTH  read data to upstream.
- pready_o  out  1  ready to upstream.
- pslverr_o  out  1  error to upstream.
- psel_o  out  NB_MASTER  one-hot downstream select.
- penable_o  out  1  downstream enable (shared by all ports).
- pwrite_o  out  1  downstream write (shared).
- paddr_o  out  APB_ADDR_WIDTH  downstream address (shared).
- pwdata_o  out  APB_DATA_WIDTH  downstream write data (shared).
- pstrb_o  out  APB_DATA_WIDTH/8  downstream strobes (shared).
- prdata_i  in  NB_MASTER x APB_DATA_WIDTH  downstream read data.
- pready_i  in  NB_MASTER  downstream ready.
- pslverr_i  in  NB_MASTER  downstream error.
- START_ADDR_i  in  NB_MASTER x APB_ADDR_WIDTH  inclusive range start.
- END_ADDR_i  in  NB_MASTER x APB_ADDR_WIDTH  inclusive range end.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - captured registers cleared.
- Reset asserted mid-transfer: abort immediately and return to IDLE. No response is issued.
- All outputs are registered. No combinational path from any input to any output.
- Decode:
  - port i hits when START_ADDR_i[i] <= addr <= END_ADDR_i[i], unsigned compare;
  - on overlap, the lowest index wins;
  - START > END means the port never hits;
  - decode is evaluated once, at capture.
- IDLE:
  - waits for psel_i=1 && penable_i=0 (upstream setup phase);
  - captures addr, wdata, strb, write and the decode result;
  - hit -> SETUP; miss -> DERR.
  - While penable_i=1, no new capture occurs, so a transfer is never re-captured.
- SETUP (1 cycle): psel_o[k]=1, penable_o=0, shared address/control/data driven -> ACCESS.
- ACCESS:
  - psel_o[k]=1, penable_o=1;
  - on pready_i[k]=1: register prdata_i[k] and pslverr_i[k], drop psel_o/penable_o -> RESP;
  - pready_i of unselected ports is ignored.
- RESP (1 cycle): pready_o=1 with the registered prdata_o and pslverr_o -> IDLE.
- DERR (1 cycle): pready_o=1, pslverr_o=1, prdata_o=0 -> IDLE. No downstream psel_o is asserted.
- Outside RESP and DERR: pready_o=0, pslverr_o=0, prdata_o=0.
- Write transfers: prdata_o=0 in RESP.
- Shared downstream buses hold the captured values from SETUP through ACCESS. They return to 0 in IDLE.
- Latency:
  - upstream setup at cycle 0, zero-wait slave -> pready_o at cycle 3;
  - each downstream wait state adds 1 cycle;
  - a decode miss gives pready_o at cycle 1.
- Upstream protocol violations (psel_i dropped mid-transfer) are ignored. The transfer completes downstream.

Optional Feature:
- Macro: APB_NODE_TIMEOUT_EN.
- Defined:
  - a $clog2(TIMEOUT_CYCLES)-bit counter clears on entering ACCESS and increments each ACCESS cycle without pready_i[k];
  - when the counter reaches TIMEOUT_CYCLES-1 with no ready: drop psel_o/penable_o and go to RESP with pslverr_o=1, prdata_o=0;
  - if pready_i arrives in the same cycle as the timeout, pready_i wins and a normal response is returned.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package apb_node_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RESP, DERR);
  - DERR_RDATA constant ('0);
  - localparam function for the strobe width.
- Sub-module apb_node_decoder (combinational) provides:
  - inputs: addr, START/END arrays;
  - outputs: one-hot sel[NB_MASTER] and hit.
- The FSM, capture registers and optional counter stay in apb_node_reg.

Test Plan:
- Write 0x1A2B3C4D to an address in port 2, zero-wait -> psel_o=0x04, pwdata_o=0x1A2B3C4D, pstrb_o=0xF at cycles 1-2; pready_o=1, pslverr_o=0 at cycle 3.
- Read from port 5 with 3 wait states, prdata_i[5]=0xCAFEF00D -> pready_o at cycle 6 with prdata_o=0xCAFEF00D, held exactly 1 cycle.
- Ports 1 and 3 with overlapping ranges, addr in the overlap -> only psel_o[1] asserted.
- Unmapped address -> pready_o=1, pslverr_o=1, prdata_o=0 at cycle 1; psel_o stays 0.
- Macro defined, TIMEOUT_CYCLES=16, slave never ready -> pslverr_o=1 response after 16 ACCESS cycles. Repeat with ready on cycle 16 -> normal response.
- rst_ni pulsed low during ACCESS -> all outputs 0 asynchronously; the next transfer completes normally.
